// File: rtl/edsac_timing_pkg.sv
// Shared EDSAC timing constants: half-cycle geometry, digit-pulse positions
// and the operation codes used by the Sequence Control Tank.
package edsac_timing_pkg;

   localparam int ADDR_W       = 10;
   localparam int HALF_LEN     = 18;
   localparam int ADDR_LSB_POS = 1;

   localparam int MAJOR_LEN    = 2 * HALF_LEN;
   localparam int D0_PI        = 0;
   localparam int D18_PI       = HALF_LEN;

   typedef enum logic [1:0] {
      OP_IDLE = 2'd0,
      OP_INC  = 2'd1,
      OP_JUMP = 2'd2
   } op_e;

endpackage

// File: rtl/sct_tank_if.sv
// MCU-side request/acknowledge bundle of the Sequence Control Tank.
interface sct_tank_if;
   logic inc_req;
   logic jump_req;
   logic jump_data;
   logic sct_ack;
   logic busy;

   modport master (output inc_req, jump_req, jump_data, input sct_ack, busy);
   modport slave  (input inc_req, jump_req, jump_data, output sct_ack, busy);
endinterface

// File: rtl/serial_incrementer.sv
// Bit-serial add-one stage: LSB-first stream in, incremented stream out.
module serial_incrementer (
   input  logic clk,
   input  logic rst_n,
   input  logic bit_i,
   input  logic carry_set_i,
   input  logic carry_clr_i,
   output logic bit_o
);

   logic carry_q, carry_d;

   assign bit_o = bit_i ^ carry_q;

   // Set wins over clear so a start at the half boundary always arms the carry.
   always_comb begin
      carry_d = bit_i & carry_q;
      if (carry_clr_i) carry_d = 1'b0;
      if (carry_set_i) carry_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) carry_q <= 1'b0;
      else        carry_q <= carry_d;
   end

endmodule

// File: rtl/sct_tank.sv
// Sequence Control Tank: recirculating serial order address with serial
// increment and jump updates, presented LSB first to the Coincidence Unit.
module sct_tank #(
   parameter int ADDR_W   = edsac_timing_pkg::ADDR_W,
   parameter int HALF_LEN = edsac_timing_pkg::HALF_LEN
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      d0,
   input  logic      d18,
   output logic      sct,
   sct_tank_if.slave mcu
);
   import edsac_timing_pkg::*;

   localparam int HPOS_W = $clog2(HALF_LEN);
   localparam logic [HPOS_W-1:0] HP_MAX   = HPOS_W'(HALF_LEN - 1);
   localparam logic [HPOS_W-1:0] HP_FIRST = HPOS_W'(ADDR_LSB_POS);
   localparam logic [HPOS_W-1:0] HP_LAST  = HPOS_W'(ADDR_LSB_POS + ADDR_W - 1);
   localparam logic [HPOS_W-1:0] HP_ACK   = HPOS_W'(ADDR_LSB_POS + ADDR_W);

   logic [HPOS_W-1:0]   hpos_q, hpos;
   logic [HALF_LEN-1:0] line_q, line_d;
   op_e                 op_q, op_d;
   logic                inc_pend_q, inc_pend_d;
   logic                jump_pend_q, jump_pend_d;
   logic                in_field, at_start, at_ack;
   logic                line_bit, inc_bit, wr_bit;
   logic                carry_set, carry_clr;

   // Position within the current half; digit pulses realign it to 0.
   always_comb begin
      hpos = '0;
      if (!(d0 || d18)) hpos = (hpos_q == HP_MAX) ? HP_MAX : hpos_q + 1'b1;
   end

   assign in_field = (hpos >= HP_FIRST) && (hpos <= HP_LAST);
   assign at_start = (hpos == '0);
   assign at_ack   = (hpos == HP_ACK);
   assign line_bit = line_q[0];
   assign sct      = in_field & line_bit;
   assign mcu.busy = inc_pend_q | jump_pend_q | (op_q != OP_IDLE);

   // Pending flags hand over to the active op at its start, so a request that
   // lands during an active half is kept for the next one.
   always_comb begin
      op_d        = op_q;
      inc_pend_d  = inc_pend_q  | mcu.inc_req;
      jump_pend_d = jump_pend_q | mcu.jump_req;
      carry_set   = 1'b0;
      mcu.sct_ack = 1'b0;
      case (op_q)
         OP_IDLE: begin
            if (at_start && (jump_pend_q || inc_pend_q)) begin
               if (jump_pend_q) begin
                  op_d = OP_JUMP;
               end else begin
                  op_d      = OP_INC;
                  carry_set = 1'b1;
               end
               inc_pend_d  = mcu.inc_req;
               jump_pend_d = mcu.jump_req;
            end
         end
         default: begin
            if (at_ack) begin
               op_d        = OP_IDLE;
               mcu.sct_ack = 1'b1;
            end
         end
      endcase
   end

   assign carry_clr = !in_field || (hpos == HP_LAST);

   serial_incrementer u_inc (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_i       (line_bit),
      .carry_set_i (carry_set),
      .carry_clr_i (carry_clr),
      .bit_o       (inc_bit)
   );

   // Outside the address field the line is always rewritten with zeros.
   always_comb begin
      wr_bit = 1'b0;
      if (in_field) wr_bit = (op_q == OP_JUMP) ? mcu.jump_data : inc_bit;
   end

   assign line_d = {wr_bit, line_q[HALF_LEN-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hpos_q      <= '0;
         line_q      <= '0;
         op_q        <= OP_IDLE;
         inc_pend_q  <= 1'b0;
         jump_pend_q <= 1'b0;
      end else begin
         hpos_q      <= hpos;
         line_q      <= line_d;
         op_q        <= op_d;
         inc_pend_q  <= inc_pend_d;
         jump_pend_q <= jump_pend_d;
      end
   end

endmodule

// File: tb/tb_sct_tank.sv
// Directed bench for sct_tank: expected addresses queue up as requests are
// issued and are compared against the serial word in the half after each ack.
module tb_sct_tank;

   logic clk = 1'b0;
   logic rst_n;
   logic d0;
   logic d18;
   logic sct;

   sct_tank_if mcu ();

   sct_tank dut (
      .clk   (clk),
      .rst_n (rst_n),
      .d0    (d0),
      .d18   (d18),
      .sct   (sct),
      .mcu   (mcu)
   );

   always #5 clk = ~clk;

   int         checks   = 0;
   int         errors   = 0;
   int         pi_cnt   = 0;
   int         ack_cnt  = 0;
   int         a0       = 0;
   logic [9:0] word     = '0;
   logic [9:0] jd_word  = '0;
   logic [9:0] addr_m   = '0;
   logic       word_due = 1'b0;
   logic [9:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One pulse interval: drive, sample on the falling edge, advance.
   task automatic pi(input logic inc, input logic jmp);
      int hp;
      hp = pi_cnt % 18;
      d0            = (pi_cnt % 36 == 0);
      d18           = (pi_cnt % 36 == 18);
      mcu.inc_req   = inc;
      mcu.jump_req  = jmp;
      mcu.jump_data = (hp >= 1 && hp <= 10) ? jd_word[hp-1] : 1'b0;
      @(negedge clk);
      if (hp >= 1 && hp <= 10) word[hp-1] = sct;
      else chk("sct_gap", 32'(sct), 32'd0);
      if (hp == 11 && word_due) begin
         word_due = 1'b0;
         if (exp_q.size() > 0) chk("sb_word", 32'(word), 32'(exp_q.pop_front()));
      end
      if (mcu.sct_ack) begin
         ack_cnt++;
         chk("ack_pos", 32'(hp), 32'd11);
         chk("ack_sb", 32'(exp_q.size() > 0), 32'd1);
         word_due = 1'b1;
      end
      @(posedge clk);
      #1;
      pi_cnt++;
   endtask

   task automatic goto(input int h);
      int n;
      n = 0;
      do begin
         pi(1'b0, 1'b0);
         n++;
      end while ((pi_cnt % 18) != h && n < 40);
   endtask

   task automatic wait_ack();
      int start;
      int n;
      start = ack_cnt;
      n     = 0;
      while (ack_cnt == start && n < 60) begin
         pi(1'b0, 1'b0);
         n++;
      end
      chk("ack_seen", 32'(ack_cnt != start), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; d0 = 1'b0; d18 = 1'b0;
      mcu.inc_req = 1'b0; mcu.jump_req = 1'b0; mcu.jump_data = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sct",  32'(sct),         32'd0);
      chk("rst_ack",  32'(mcu.sct_ack), 32'd0);
      chk("rst_busy", 32'(mcu.busy),    32'd0);
      rst_n  = 1'b1;
      pi_cnt = 0;

      // Idle halves
      for (int h = 0; h < 10; h++) begin
         goto(12);
         chk("idle_word", 32'(word), 32'd0);
         chk("idle_busy", 32'(mcu.busy), 32'd0);
      end

      // Three increments from 0
      for (int k = 0; k < 3; k++) begin
         goto(3);
         pi(1'b1, 1'b0);
         addr_m = addr_m + 10'd1;
         exp_q.push_back(addr_m);
         wait_ack();
      end
      goto(12);
      chk("inc3_word", 32'(word), 32'd3);

      // Jump to all-ones, then increment wraps to 0, then carry must be clear
      a0 = ack_cnt;
      jd_word = 10'h3FF;
      goto(3);
      pi(1'b0, 1'b1);
      addr_m = 10'h3FF;
      exp_q.push_back(addr_m);
      wait_ack();
      goto(3);
      pi(1'b1, 1'b0);
      addr_m = 10'h000;
      exp_q.push_back(addr_m);
      wait_ack();
      goto(12);
      chk("wrap_word", 32'(word), 32'd0);
      chk("wrap_acks", 32'(ack_cnt - a0), 32'd2);
      goto(3);
      pi(1'b1, 1'b0);
      addr_m = 10'h001;
      exp_q.push_back(addr_m);
      wait_ack();
      goto(12);
      chk("post_wrap_word", 32'(word), 32'd1);

      // Simultaneous inc and jump: jump wins, one ack
      a0 = ack_cnt;
      jd_word = 10'h155;
      goto(3);
      pi(1'b1, 1'b1);
      addr_m = 10'h155;
      exp_q.push_back(addr_m);
      wait_ack();
      goto(12);
      goto(12);
      chk("both_word", 32'(word), 32'h155);
      chk("both_acks", 32'(ack_cnt - a0), 32'd1);
      chk("both_busy", 32'(mcu.busy), 32'd0);

      // Increment requested during an active increment half
      a0 = ack_cnt;
      goto(3);
      pi(1'b1, 1'b0);
      addr_m = addr_m + 10'd1;
      exp_q.push_back(addr_m);
      goto(0);
      goto(5);
      pi(1'b1, 1'b0);
      addr_m = addr_m + 10'd1;
      exp_q.push_back(addr_m);
      wait_ack();
      chk("busy_second", 32'(mcu.busy), 32'd1);
      wait_ack();
      goto(12);
      chk("plus2_word", 32'(word), 32'h157);
      chk("plus2_acks", 32'(ack_cnt - a0), 32'd2);

      // Reset in the middle of an increment half
      goto(3);
      pi(1'b1, 1'b0);
      goto(0);
      goto(6);
      a0 = ack_cnt;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sct",  32'(sct),         32'd0);
      chk("mid_rst_ack",  32'(mcu.sct_ack), 32'd0);
      chk("mid_rst_busy", 32'(mcu.busy),    32'd0);
      d0 = 1'b0; d18 = 1'b0; mcu.inc_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      pi_cnt = 0;
      goto(12);
      goto(12);
      chk("post_rst_word", 32'(word), 32'd0);
      chk("post_rst_acks", 32'(ack_cnt - a0), 32'd0);
      chk("post_rst_busy", 32'(mcu.busy), 32'd0);

      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
